clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Runtime-programmable integer clock divider, the parametrised successor to the fixed divide-by-4 block. It generates a near-50% duty divided output `clko` and a one-cycle `tick` strobe from a single system clock. The ratio can be changed while running and takes effect only at a period boundary, so `clko` never produces a runt pulse. It sits beside the timing/peripheral logic and supplies slow enables and derived clocks.

## Interface
- `WIDTH`, 8: width of the divide ratio.
- `DEFAULT_DIV`, 4: ratio loaded at reset; must fit in `WIDTH` bits.
- `clk` input 1: system clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `en` input 1: run request.
- `div` input `WIDTH`: new ratio N, sampled when `load`=1.
- `load` input 1: single-cycle strobe to capture `div`.
- `clko` output 1: registered divided output.
- `tick` output 1: registered strobe, high for one `clk` cycle at each `clko` rising edge.
- `div_cur` output `WIDTH`: ratio currently in effect.

## Operation
- Registers:
  - `state`: IDLE or RUN.
  - `cnt`: `WIDTH` bits, the phase within the current period.
  - `cur_div`: the ratio in effect.
  - `pend_div` and `pend_vld`: a pending ratio and its valid flag.
  - `clko`, `tick`.
- High time H = (N+1)>>1, where N = `cur_div`.
  - In RUN, `clko` = (`cnt` < H) in the same cycle as `cnt`.
  - Even N gives exactly 50% duty. Odd N is high one cycle longer than low.
- `tick` = 1 exactly when state is RUN and `cnt` = 0.
- IDLE:
  - `cnt` = 0, `clko` = 0, `tick` = 0.
  - `load` writes `div` directly into `cur_div` on the next edge. `pend_vld` stays 0.
  - If `en`=1 and `cur_div`≠0 in the same cycle, go to RUN. The next cycle shows `cnt`=0, `clko`=1, `tick`=1.
- RUN:
  - `cnt` increments each cycle until `cnt` = N−1. That cycle is the boundary.
  - `load` outside the boundary writes `pend_div` and sets `pend_vld`. If `load` repeats before the boundary, the last value wins.
- At the boundary, evaluated in priority order:
  1. `en`=0: go to IDLE. A pending value (including a same-cycle `load`) is transferred to `cur_div`.
  2. `load`=1 this cycle: `div` becomes `cur_div` immediately. It is not queued.
  3. `pend_vld`=1: `pend_div` becomes `cur_div` and `pend_vld` clears.
  4. Otherwise: `cnt` goes to 0 and a new period starts.
  - If the resulting `cur_div` is 0, go to IDLE instead of starting a period.
- N = 1: `clko` is constantly 1 and `tick` is high every cycle while in RUN.
- N = 0: invalid. The block cannot enter RUN and sits in IDLE with `clko` = 0.
- Deasserting `en` mid-period does not truncate the period. It completes to the boundary, then stops.
- `div_cur` always reflects `cur_div`.
- Reset values: state IDLE, `cnt` 0, `cur_div` `DEFAULT_DIV`, `pend_div` 0, `pend_vld` 0, `clko` 0, `tick` 0, `div_cur` `DEFAULT_DIV`.
- Reset asserted mid-run forces all reset values immediately (asynchronously). After release, the block waits in IDLE for `en`.

## Timing
- Start latency: `en` sampled high in IDLE leads to `clko`/`tick` high on the following edge, i.e. 1 cycle.
- Period: exactly N `clk` cycles, rising edge to rising edge, with no jitter.
- Ratio change latency: the new N applies from the first period starting after the next boundary. A `load` in the boundary cycle applies to the immediately following period.
- Stop latency: 0 to N−1 cycles after `en` falls. `clko` goes low on the edge after the boundary.
- `clko` and `tick` are flop outputs with no combinational path from inputs.
- `cnt` never exceeds N−1. There is no wrap-around beyond the period.

## Test plan
- **Reset:** hold `rst`=0 for 6 cycles, release with `en`=0.
  - Required: `clko`=0, `tick`=0, `div_cur`=4 throughout, and state stays IDLE.
- **Even and odd ratios:**
  - With `en`=1 and default N=4, `clko` repeats 1,1,0,0 with a `tick` every 4th cycle, first `tick` one cycle after `en`.
  - With N=5 loaded in IDLE, `clko` repeats 1,1,1,0,0.
- **Mid-run change:**
  - While running N=4, pulse `load` with `div`=6 at `cnt`=1. The current period completes with 4 cycles, then periods are 6 cycles (3 high/3 low), and `div_cur` changes to 6 at the boundary.
  - A second `load` with 2 before that boundary yields N=2 instead of 6.
- **Stop:**
  - Drop `en` at `cnt`=1 with N=4. `clko` finishes the 1,1,0,0 period, then stays 0 and `tick` stops.
  - Reasserting `en` restarts at `cnt`=0 after 1 cycle.
- **Edge ratios:**
  - N=1 gives `clko`=1 and `tick`=1 every cycle.
  - Loading N=0 while running stops at the boundary with `clko`=0. `en`=1 with N=0 never leaves IDLE.
- **Async reset mid-run:** assert `rst`=0 between edges during a `clko`-high phase.
  - `clko` and `tick` drop immediately, and `div_cur` returns to 4.
  - After release with `en`=1, the output restarts cleanly one cycle later.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control/status bundle for the programmable clock divider
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div;
    logic             load;
    logic             clko;
    logic             tick;
    logic [WIDTH-1:0] div_cur;

    modport master (
        output en,
        output div,
        output load,
        input  clko,
        input  tick,
        input  div_cur
    );

    modport slave (
        input  en,
        input  div,
        input  load,
        output clko,
        output tick,
        output div_cur
    );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with glitch-free ratio change
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [0:0]       state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] cur_div, cur_div_n;
    logic [WIDTH-1:0] pend_div, pend_div_n;
    logic             pend_vld, pend_vld_n;
    logic             clko_q, clko_n;
    logic             tick_q, tick_n;

    logic             boundary;
    logic [WIDTH:0]   high_n;

    // Last phase of the period: the only point where the ratio may change or the divider may stop
    assign boundary = (state == ST_RUN) && (cnt == cur_div - WIDTH'(1));

    // Next-state computation for phase, ratio and pending ratio
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cur_div_n  = cur_div;
        pend_div_n = pend_div;
        pend_vld_n = pend_vld;

        if (state == ST_IDLE) begin
            cnt_n      = '0;
            pend_vld_n = 1'b0;
            if (bus.load) begin
                cur_div_n = bus.div;
            end
            // A same-cycle load of zero must not start a period that could never reach its boundary
            if (bus.en && (cur_div != '0) && !(bus.load && (bus.div == '0))) begin
                state_n = ST_RUN;
            end
        end else if (!boundary) begin
            cnt_n = cnt + WIDTH'(1);
            if (bus.load) begin
                pend_div_n = bus.div;
                pend_vld_n = 1'b1;
            end
        end else begin
            cnt_n      = '0;
            pend_vld_n = 1'b0;
            // A load in the boundary cycle is the newest value, so it beats anything pending
            if (bus.load) begin
                cur_div_n = bus.div;
            end else if (pend_vld) begin
                cur_div_n = pend_div;
            end
            if (!bus.en || (cur_div_n == '0)) begin
                state_n = ST_IDLE;
            end
        end
    end

    // High time of the period that the next cycle belongs to; one bit wider so N=max cannot overflow
    assign high_n = ({1'b0, cur_div_n} + (WIDTH + 1)'(1)) >> 1;

    // Output decode is done on next-state values so clko/tick come straight from flops
    always_comb begin
        clko_n = 1'b0;
        tick_n = 1'b0;
        if (state_n == ST_RUN) begin
            clko_n = ({1'b0, cnt_n} < high_n);
            tick_n = (cnt_n == '0);
        end
    end

    // State, ratio and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_div  <= DIV_RST;
            pend_div <= '0;
            pend_vld <= 1'b0;
            clko_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_div  <= cur_div_n;
            pend_div <= pend_div_n;
            pend_vld <= pend_vld_n;
            clko_q   <= clko_n;
            tick_q   <= tick_n;
        end
    end

    assign bus.clko    = clko_q;
    assign bus.tick    = tick_q;
    assign bus.div_cur = cur_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    clk_div_prog_if #(.WIDTH(8)) bus ();

    clk_div_prog #(
        .WIDTH       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge, then check outputs 1ns later
    task automatic cyc(input string tag, input logic exp_clko, input logic exp_tick);
        @(posedge clk);
        #1;
        chk({tag, ".clko"}, 32'(bus.clko), 32'(exp_clko));
        chk({tag, ".tick"}, 32'(bus.tick), 32'(exp_tick));
    endtask

    // n cycles of expected clko/tick, oldest cycle in bit n-1
    task automatic seq(input string tag, input int n, input logic [31:0] cv, input logic [31:0] tv);
        for (int i = n - 1; i >= 0; i--) begin
            cyc($sformatf("%s[%0d]", tag, n - 1 - i), cv[i], tv[i]);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.div  = 8'd0;

        // Reset held, then released with en low
        for (int i = 0; i < 6; i++) begin
            cyc("rst", 1'b0, 1'b0);
            chk("rst.div_cur", 32'(bus.div_cur), 32'd4);
        end
        rst = 1'b1;
        cyc("idle0", 1'b0, 1'b0);
        cyc("idle1", 1'b0, 1'b0);
        chk("idle.div_cur", 32'(bus.div_cur), 32'd4);

        // Default N=4
        bus.en = 1'b1;
        seq("n4", 8, 32'b11001100, 32'b10001000);

        // Mid-run load of 6 at cnt=1
        cyc("n4b0", 1'b1, 1'b1);
        cyc("n4b1", 1'b1, 1'b0);
        bus.load = 1'b1;
        bus.div  = 8'd6;
        cyc("ld6a", 1'b0, 1'b0);
        bus.load = 1'b0;
        chk("ld6.pend_div_cur", 32'(bus.div_cur), 32'd4);
        cyc("ld6b", 1'b0, 1'b0);
        chk("ld6.bnd_div_cur", 32'(bus.div_cur), 32'd4);
        seq("n6", 12, 32'b111000111000, 32'b100000100000);
        chk("n6.div_cur", 32'(bus.div_cur), 32'd6);

        // Two loads before the boundary: last (2) wins
        cyc("n6c0", 1'b1, 1'b1);
        cyc("n6c1", 1'b1, 1'b0);
        bus.load = 1'b1;
        bus.div  = 8'd6;
        cyc("n6c2", 1'b1, 1'b0);
        bus.div  = 8'd2;
        cyc("n6c3", 1'b0, 1'b0);
        bus.load = 1'b0;
        cyc("n6c4", 1'b0, 1'b0);
        cyc("n6c5", 1'b0, 1'b0);
        seq("n2", 6, 32'b101010, 32'b101010);
        chk("n2.div_cur", 32'(bus.div_cur), 32'd2);

        // Load in the boundary cycle applies immediately
        bus.load = 1'b1;
        bus.div  = 8'd4;
        cyc("bnd4", 1'b1, 1'b1);
        bus.load = 1'b0;
        chk("bnd4.div_cur", 32'(bus.div_cur), 32'd4);
        cyc("bnd4b", 1'b1, 1'b0);

        // Stop at cnt=1: period completes, then idle
        bus.en = 1'b0;
        cyc("stop2", 1'b0, 1'b0);
        cyc("stop3", 1'b0, 1'b0);
        seq("stopped", 4, 32'b0000, 32'b0000);

        // Restart one cycle after en
        bus.en = 1'b1;
        seq("restart", 5, 32'b11001, 32'b10001);

        // N=1 via pending load
        bus.load = 1'b1;
        bus.div  = 8'd1;
        cyc("ld1a", 1'b1, 1'b0);
        bus.load = 1'b0;
        cyc("ld1b", 1'b0, 1'b0);
        cyc("ld1c", 1'b0, 1'b0);
        seq("n1", 5, 32'b11111, 32'b11111);
        chk("n1.div_cur", 32'(bus.div_cur), 32'd1);

        // N=0 while running: stops, then en=1 cannot leave idle
        bus.load = 1'b1;
        bus.div  = 8'd0;
        cyc("n0", 1'b0, 1'b0);
        bus.load = 1'b0;
        chk("n0.div_cur", 32'(bus.div_cur), 32'd0);
        seq("n0idle", 4, 32'b0000, 32'b0000);

        // N=5 loaded in idle, en held high
        bus.load = 1'b1;
        bus.div  = 8'd5;
        cyc("ld5", 1'b0, 1'b0);
        bus.load = 1'b0;
        chk("ld5.div_cur", 32'(bus.div_cur), 32'd5);
        seq("n5", 10, 32'b1110011100, 32'b1000010000);

        // Asynchronous reset during a clko-high phase
        cyc("pre_rst", 1'b1, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst.clko", 32'(bus.clko), 32'd0);
        chk("arst.tick", 32'(bus.tick), 32'd0);
        chk("arst.div_cur", 32'(bus.div_cur), 32'd4);
        cyc("arst_hold", 1'b0, 1'b0);
        rst = 1'b1;
        seq("post_rst", 5, 32'b11001, 32'b10001);
        chk("post_rst.div_cur", 32'(bus.div_cur), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
